// File: rtl/byte_serial_add_arbiter.sv
// byte_serial_add_arbiter
//   Shares one 8-bit byte adder between two requesters. A round-robin arbiter
//   accepts one wide add (8*OP_BYTES bits) at a time. The operation is then
//   summed least-significant byte first, one byte per clock, with the carry
//   chained through a register. The result comes back on a valid/ready
//   response port, tagged with the owning requester's ID.
//
// Ports
//   clk                  system clock, all state changes on the rising edge
//   rst_n                synchronous active-low reset
//   req0_valid/ready     requester 0 handshake; req0_a/req0_b are its operands
//   req1_valid/ready     requester 1 handshake; req1_a/req1_b are its operands
//   rsp_valid/ready      response handshake
//   rsp_id               requester that owns the response
//   rsp_sum              (A+B) mod 2^W
//   rsp_cout             carry out of the most significant byte
//   busy                 high whenever the controller is not idle
module byte_serial_add_arbiter #(
    parameter int OP_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [8*OP_BYTES-1:0]   req0_a,
    input  logic [8*OP_BYTES-1:0]   req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [8*OP_BYTES-1:0]   req1_a,
    input  logic [8*OP_BYTES-1:0]   req1_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [8*OP_BYTES-1:0]   rsp_sum,
    output logic                    rsp_cout,
    output logic                    busy
);
    localparam int W     = 8 * OP_BYTES;
    localparam int IDX_W = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OP_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       acc_q, acc_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [W-1:0]       rsp_sum_q, rsp_sum_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic               rsp_id_q, rsp_id_d;

    // Operands viewed as byte lanes so the active byte is a plain array select.
    logic [7:0] a_byte [OP_BYTES];
    logic [7:0] b_byte [OP_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < OP_BYTES; gi++) begin : g_lane
            assign a_byte[gi] = a_q[gi*8 +: 8];
            assign b_byte[gi] = b_q[gi*8 +: 8];
        end
    endgenerate

    logic [8:0] byte_sum;
    assign byte_sum = {1'b0, a_byte[idx_q]} + {1'b0, b_byte[idx_q]} + {8'd0, carry_q};

    // Under contention the requester that did not win last time is chosen.
    // last_grant_q resets to 1, so requester 0 wins the first contention.
    logic gnt0, gnt1, idle;
    assign idle = (state_q == IDLE);
    assign gnt0 = req0_valid && (!req1_valid || last_grant_q);
    assign gnt1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = idle && gnt0;
    assign req1_ready = idle && gnt1;
    assign rsp_valid  = (state_q == DONE);
    assign busy       = !idle;
    assign rsp_sum    = rsp_sum_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_id     = rsp_id_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d          = gnt1 ? req1_a : req0_a;
                    b_d          = gnt1 ? req1_b : req0_b;
                    owner_d      = gnt1;
                    last_grant_d = gnt1;
                    carry_d      = 1'b0;
                    idx_d        = '0;
                    state_d      = ADD;
                end
            end
            ADD: begin
                acc_d[idx_q*8 +: 8] = byte_sum[7:0];
                carry_d             = byte_sum[8];
                if (idx_q == LAST_IDX) begin
                    // The accumulator is private, so the response registers
                    // only change once a complete result exists.
                    rsp_sum_d  = acc_d;
                    rsp_cout_d = byte_sum[8];
                    rsp_id_d   = owner_q;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_id_q     <= rsp_id_d;
        end
    end
endmodule

// File: tb/tb_byte_serial_add_arbiter.sv
module tb_byte_serial_add_arbiter;
    localparam int OP_BYTES = 4;
    localparam int W        = 8 * OP_BYTES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
    logic [W-1:0] rsp_sum;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_last   = 1'b1;   // reference model: last granted requester

    byte_serial_add_arbiter #(.OP_BYTES(OP_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: the full W+1 bit sum of two unsigned operands.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int g, output bit to);
        int n = 0;
        g  = -1;
        to = 1'b0;
        #1;
        while (!(req0_ready || req1_ready)) begin
            if (n >= 40) begin to = 1'b1; return; end
            tick();
            n++;
        end
        g = req1_ready ? 1 : 0;
    endtask

    task automatic wait_rsp(output int lat, output bit to);
        lat = 0;
        to  = 1'b0;
        while (!rsp_valid) begin
            if (lat >= 40) begin to = 1'b1; return; end
            tick();
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Runs one operation from whatever valids/operands the caller set up.
    // Only the granted requester drops its valid; the other keeps waiting.
    task automatic do_op(output int g, output int lat, output bit to,
                         output logic [W-1:0] sum, output logic cout, output logic id);
        bit to2;
        lat = 0; sum = '0; cout = 1'b0; id = 1'b0;
        wait_grant(g, to);
        if (to) return;
        tick();
        if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        wait_rsp(lat, to2);
        to = to2;
        if (to) return;
        sum = rsp_sum; cout = rsp_cout; id = rsp_id;
        take_rsp();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        m_last = 1'b1;
        tick();
        n_checks++;
        if ({rsp_valid, busy, rsp_cout, rsp_id, req0_ready, req1_ready} !== 6'b0 || rsp_sum !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b busy=%b cout=%b id=%b rdy=%b%b sum=%h, required all 0",
                     rsp_valid, busy, rsp_cout, rsp_id, req0_ready, req1_ready, rsp_sum);
        end
        $display("reset: rsp_valid=%b busy=%b sum=%h", rsp_valid, busy, rsp_sum);
    endtask

    task automatic test_single_add();
        int g, lat; bit to;
        logic [W:0] exp;
        req0_a = 32'h0000_00FF; req0_b = 32'h0000_0001; req0_valid = 1'b1;
        exp = ref_add(req0_a, req0_b);
        wait_grant(g, to);
        n_checks++;
        if (to || g != 0) begin
            n_fail++; $display("FAIL single_grant: got grant %0d timeout=%b, required 0", g, to);
        end
        tick();
        req0_valid = 1'b1;   // still asserted: ready must nevertheless be low now
        #1;
        n_checks++;
        if (req0_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_ready_pulse: ready=%b busy=%b, required 0/1", req0_ready, busy);
        end
        req0_valid = 1'b0;
        m_last = 1'b0;
        wait_rsp(lat, to);
        n_checks++;
        if (to || lat != OP_BYTES) begin
            n_fail++; $display("FAIL single_latency: got %0d timeout=%b, required %0d", lat, to, OP_BYTES);
        end
        n_checks++;
        if (rsp_sum !== exp[W-1:0] || rsp_cout !== exp[W] || rsp_id !== 1'b0) begin
            n_fail++; $display("FAIL single_result: sum=%h cout=%b id=%b, required %h/%b/0",
                               rsp_sum, rsp_cout, rsp_id, exp[W-1:0], exp[W]);
        end
        $display("single: %h + %h -> sum=%h cout=%b id=%b lat=%0d", req0_a, req0_b, rsp_sum, rsp_cout, rsp_id, lat);
        take_rsp();
    endtask

    task automatic test_overflow();
        int g, lat; bit to;
        logic [W-1:0] s; logic c, id;
        logic [W:0] exp;
        req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_0001; req1_valid = 1'b1;
        exp = ref_add(req1_a, req1_b);
        do_op(g, lat, to, s, c, id);
        m_last = 1'b1;
        n_checks++;
        if (to || s !== exp[W-1:0] || c !== exp[W] || id !== 1'b1) begin
            n_fail++; $display("FAIL overflow: sum=%h cout=%b id=%b timeout=%b, required %h/%b/1",
                               s, c, id, to, exp[W-1:0], exp[W]);
        end
        $display("overflow: sum=%h cout=%b id=%b", s, c, id);
    endtask

    task automatic test_round_robin();
        int g, lat; bit to;
        logic [W-1:0] s; logic c, id;
        logic [W:0] exp0, exp1, exp;
        int exp_g;
        test_reset();
        req0_a = 32'h1111_1111; req0_b = 32'h2222_2222;
        req1_a = 32'h0102_0304; req1_b = 32'h1020_3040;
        exp0 = ref_add(req0_a, req0_b);
        exp1 = ref_add(req1_a, req1_b);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 0 : 1;
            do_op(g, lat, to, s, c, id);
            // The just-served requester comes straight back with the same op.
            req0_valid = 1'b1; req1_valid = 1'b1;
            exp = (exp_g == 0) ? exp0 : exp1;
            n_checks++;
            if (to || g != exp_g || id !== exp_g[0] || s !== exp[W-1:0] || c !== exp[W]) begin
                n_fail++; $display("FAIL round_robin_%0d: grant=%0d id=%b sum=%h cout=%b timeout=%b, required %0d/%h/%b",
                                   k, g, id, s, c, to, exp_g, exp[W-1:0], exp[W]);
            end
            $display("round_robin %0d: grant=%0d sum=%h id=%b", k, g, s, id);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic test_backpressure();
        int g, lat; bit to, bad;
        logic [W-1:0] held;
        logic [W:0] exp;
        req0_a = 32'hDEAD_BEEF; req0_b = 32'h3000_0000; req0_valid = 1'b1;
        exp = ref_add(req0_a, req0_b);
        wait_grant(g, to);
        tick();
        req0_valid = 1'b0;
        m_last = 1'b0;
        wait_rsp(lat, to);
        held = rsp_sum;
        n_checks++;
        if (to || held !== exp[W-1:0] || rsp_cout !== exp[W]) begin
            n_fail++; $display("FAIL bp_result: sum=%h cout=%b timeout=%b, required %h/%b", held, rsp_cout, to, exp[W-1:0], exp[W]);
        end
        // New requests arrive while the response is stalled.
        req1_a = 32'h0000_0005; req1_b = 32'h0000_0007; req1_valid = 1'b1;
        req0_valid = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_sum !== held || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL bp_hold: valid=%b sum=%h rdy=%b%b, required 1/%h/00", rsp_valid, rsp_sum, req0_ready, req1_ready, held);
        end
        req0_valid = 1'b0;
        take_rsp();
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: busy=%b valid=%b req1_ready=%b, required 0/0/1", busy, rsp_valid, req1_ready);
        end
        $display("backpressure: held sum=%h, released", held);
        tick();
        req1_valid = 1'b0;
        m_last = 1'b1;
        exp = ref_add(req1_a, req1_b);
        wait_rsp(lat, to);
        n_checks++;
        if (to || lat != OP_BYTES || rsp_sum !== exp[W-1:0] || rsp_id !== 1'b1) begin
            n_fail++; $display("FAIL bp_next_op: sum=%h id=%b lat=%0d, required %h/1/%0d", rsp_sum, rsp_id, lat, exp[W-1:0], OP_BYTES);
        end
        take_rsp();
    endtask

    task automatic test_reset_mid_op();
        int g, lat; bit to, bad;
        logic [W-1:0] s; logic c, id;
        logic [W:0] exp;
        req0_a = 32'h1234_5678; req0_b = 32'h0FED_CBA9; req0_valid = 1'b1;
        wait_grant(g, to);
        tick();              // accept
        req0_valid = 1'b0;
        tick(); tick();      // bytes 0 and 1 done, byte 2 in progress
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_last = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_idle: busy=%b valid=%b, required 0/0", busy, rsp_valid);
        end
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL midreset_no_rsp: a response or activity appeared after reset");
        end
        req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001; req0_valid = 1'b1;
        exp = ref_add(req0_a, req0_b);
        do_op(g, lat, to, s, c, id);
        m_last = 1'b0;
        n_checks++;
        if (to || s !== exp[W-1:0] || c !== exp[W] || id !== 1'b0 || lat != OP_BYTES) begin
            n_fail++; $display("FAIL midreset_next: sum=%h cout=%b id=%b lat=%0d, required %h/%b/0/%0d",
                               s, c, id, lat, exp[W-1:0], exp[W], OP_BYTES);
        end
        $display("reset_mid_op: follow-up sum=%h cout=%b", s, c);
    endtask

    task automatic test_random();
        int g, lat, exp_g; bit to;
        logic [W-1:0] s; logic c, id;
        logic [W:0] exp;
        bit pend0, pend1;
        pend0 = 1'b0; pend1 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            // Requesters that are not already waiting may post a new operation.
            if (!pend0 && ($urandom_range(0, 1) == 1)) begin
                pend0 = 1'b1; req0_a = $urandom(); req0_b = $urandom();
            end
            if (!pend1 && ($urandom_range(0, 1) == 1)) begin
                pend1 = 1'b1; req1_a = $urandom(); req1_b = $urandom();
            end
            if (!pend0 && !pend1) begin
                pend0 = 1'b1; req0_a = $urandom(); req0_b = $urandom();
            end
            req0_valid = pend0; req1_valid = pend1;
            exp_g = (pend0 && pend1) ? (m_last ? 0 : 1) : (pend1 ? 1 : 0);
            exp = (exp_g == 0) ? ref_add(req0_a, req0_b) : ref_add(req1_a, req1_b);
            do_op(g, lat, to, s, c, id);
            if (exp_g == 0) pend0 = 1'b0; else pend1 = 1'b0;
            m_last = exp_g[0];
            n_checks++;
            if (to || g != exp_g || id !== exp_g[0] || s !== exp[W-1:0] || c !== exp[W] || lat != OP_BYTES) begin
                n_fail++; $display("FAIL random_%0d: grant=%0d id=%b sum=%h cout=%b lat=%0d, required %0d/%h/%b/%0d",
                                   k, g, id, s, c, lat, exp_g, exp[W-1:0], exp[W], OP_BYTES);
            end
            $display("random %0d: grant=%0d sum=%h cout=%b", k, g, s, c);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/byte_serial_add_arbiter.md
Name: byte_serial_add_arbiter

Overview:
Shares one 8-bit ripple-carry byte adder between two requesters. Each requester submits a wide add of 8*OP_BYTES bits. The controller arbitrates round-robin, captures the operands, and sequences the byte adder least-significant byte first, one byte per clock, chaining the carry through a register. It returns the sum, the carry-out and the requester ID on a valid/ready response port, and sits between the arithmetic clients and the adder datapath.

Parameters:
OP_BYTES, 4, operand width in bytes; operand width W = 8*OP_BYTES; legal range 1..16.

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
req0_a  in  W  requester 0 operand A
req0_b  in  W  requester 0 operand B
req1_valid  in  1  requester 1 has an operation pending
req1_ready  out  1  requester 1 operation accepted this cycle when high with req1_valid
req1_a  in  W  requester 1 operand A
req1_b  in  W  requester 1 operand B
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes the response
rsp_id  out  1  ID of the requester that owns the response
rsp_sum  out  W  (A+B) mod 2^W
rsp_cout  out  1  carry out of the most significant byte
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, when rst_n=0 at an edge:
  - state goes to IDLE; byte index = 0; carry register = 0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0.
  - last_grant=1, so requester 0 wins the first contention.
- Reset mid-operation aborts the operation. The in-flight result is discarded, no response is issued, and the requester is not re-notified.
- States:
  - IDLE -> ADD on acceptance.
  - ADD -> DONE after byte OP_BYTES-1.
  - DONE -> IDLE on rsp_valid && rsp_ready.
- Arbitration, IDLE only:
  - The grant is combinational from the current valids.
  - Single valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high per cycle.
  - Both readys are low in ADD and DONE.
  - On acceptance, capture A and B, set owner ID, set last_grant=owner, clear carry and byte index, and go to ADD.
  - Requesters must hold valid and operands stable until ready. Operands are sampled only on the accept edge.
- ADD, one byte per cycle, byte index i = 0..OP_BYTES-1:
  - {c, s} = A[8i+7:8i] + B[8i+7:8i] + carry_reg (9-bit result).
  - s is written to sum byte i; carry_reg <= c; i increments.
  - At i = OP_BYTES-1: rsp_cout <= c and the state goes to DONE.
- Latency: accept at edge T; rsp_valid is high from edge T+OP_BYTES onward (OP_BYTES cycles in ADD).
- DONE:
  - rsp_valid=1. rsp_sum, rsp_cout and rsp_id are held stable until the handshake.
  - On handshake, rsp_valid drops at the next edge and the state returns to IDLE.
  - The next acceptance is possible in the first IDLE cycle.
  - Peak throughput: one operation per OP_BYTES+2 cycles.
- rsp_sum, rsp_cout and rsp_id keep their last values in IDLE and ADD. They are only meaningful while rsp_valid=1.
- Requests that arrive while busy are held off by the requester (ready stays low). No request is lost, and the arbiter keeps no queue.
- Overflow: the sum wraps modulo 2^W, and the carry is reported only via rsp_cout.
- Width rule: sum bytes beyond the processed index may hold stale data during ADD. Only the DONE value is architecturally visible.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> rsp_valid=0, busy=0, rsp_sum=0, both readys low with no valids.
- Single add (OP_BYTES=4): req0 A=0x000000FF, B=0x00000001 -> req0_ready for 1 cycle; rsp_valid at accept+4; rsp_sum=0x00000100, rsp_cout=0, rsp_id=0. The carry must ripple across the byte 0->1 boundary.
- Full overflow: req1 A=0xFFFFFFFF, B=0x00000001 -> rsp_sum=0x00000000, rsp_cout=1, rsp_id=1.
- Round-robin: req0 and req1 both valid continuously with distinct operands (0x11111111+0x22222222, 0x01020304+0x10203040) -> grants alternate 0,1,0,1. Sums are 0x33333333 and 0x11223344, each with the correct rsp_id. Neither requester is granted twice in a row while the other waits.
- Response backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid stays 1, outputs stable, both readys low. After rsp_ready=1 for one cycle -> IDLE next edge, new accept possible the following cycle.
- Reset mid-op: assert rst_n=0 at ADD byte 2 -> next edge IDLE, rsp_valid=0, no response emitted. The next request then completes correctly (0x7FFFFFFF+0x00000001 -> 0x80000000, cout=0).
